// File: rtl/bp_be_pkg.sv
// Shared backend register-file types: configuration, write packet and write-port resolution.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0
    } bp_params_e;

    localparam int unsigned reg_addr_width_gp  = 5;
    localparam int unsigned max_data_width_gp  = 65;
    localparam int unsigned wr_ports_max_gp    = 4;
    localparam int unsigned wr_idx_width_gp    = 2;

    // Write packet sized for the widest file; narrower files zero-extend their data.
    typedef struct packed {
        logic                         v;
        logic [reg_addr_width_gp-1:0] addr;
        logic [max_data_width_gp-1:0] data;
    } bp_be_wr_pkt_s;

    typedef struct packed {
        logic                       hit;
        logic [wr_idx_width_gp-1:0] idx;
    } bp_be_wr_sel_s;

    // Register address width implied by a processor configuration.
    function automatic int unsigned bp_cfg_reg_addr_width(input bp_params_e cfg);
        int unsigned width;
        width = reg_addr_width_gp;
        if (cfg != e_bp_default_cfg) width = reg_addr_width_gp;
        return width;
    endfunction

    // Highest-indexed valid write port targeting addr wins; x0 writes are dropped when drop_x0 is set.
    function automatic bp_be_wr_sel_s bp_be_resolve_write(
        input bp_be_wr_pkt_s [wr_ports_max_gp-1:0] pkts,
        input logic [reg_addr_width_gp-1:0]        addr,
        input logic                                drop_x0
    );
        bp_be_wr_sel_s sel;
        sel = '0;
        for (int unsigned p = 0; p < wr_ports_max_gp; p++) begin
            if (pkts[p].v && (pkts[p].addr == addr) && !(drop_x0 && (addr == '0))) begin
                sel.hit = 1'b1;
                sel.idx = wr_idx_width_gp'(p);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/bp_be_regfile_read_slot.sv
// One read port: held address, registered operand, and hold-replace from the write ports.
module bp_be_regfile_read_slot
    import bp_be_pkg::*;
#(
    parameter int unsigned data_width_p = 64,
    parameter bit          zero_x0_p    = 1'b1
)(
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                rs_r_v_i,
    input  logic [reg_addr_width_gp-1:0]        rs_addr_i,
    input  logic [data_width_p-1:0]             rd_fwd_data_i,
    input  bp_be_wr_pkt_s [wr_ports_max_gp-1:0] wr_pkts_i,
    output logic [data_width_p-1:0]             rs_data_o
);

    logic [reg_addr_width_gp-1:0] held_addr_r;
    logic [reg_addr_width_gp-1:0] held_addr_n;
    logic [data_width_p-1:0]      data_r;
    logic [data_width_p-1:0]      data_n;
    bp_be_wr_sel_s                hold_sel;

    // New request captures address and write-first data; otherwise follow writes to the held address.
    always_comb begin
        held_addr_n = held_addr_r;
        data_n      = data_r;
        hold_sel    = bp_be_resolve_write(wr_pkts_i, held_addr_r, zero_x0_p);
        if (rs_r_v_i) begin
            held_addr_n = rs_addr_i;
            data_n      = rd_fwd_data_i;
        end else if (hold_sel.hit) begin
            data_n = data_width_p'(wr_pkts_i[hold_sel.idx].data);
        end
    end

    // Held address and output register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            held_addr_r <= '0;
            data_r      <= '0;
        end else begin
            held_addr_r <= held_addr_n;
            data_r      <= data_n;
        end
    end

    assign rs_data_o = data_r;

endmodule

// File: rtl/bp_be_regfile_mp.sv
// Parametrised multi-write, multi-read register file with per-port held operands.
module bp_be_regfile_mp
    import bp_be_pkg::*;
#(
    parameter bp_params_e  bp_params_p   = e_bp_default_cfg,
    parameter int unsigned data_width_p  = 64,
    parameter int unsigned read_ports_p  = 2,
    parameter int unsigned write_ports_p = 2,
    parameter bit          zero_x0_p     = 1'b1,
    localparam int unsigned addr_width_lp = bp_cfg_reg_addr_width(bp_params_p)
)(
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [read_ports_p-1:0]                rs_r_v_i,
    input  logic [read_ports_p*addr_width_lp-1:0]  rs_addr_i,
    output logic [read_ports_p*data_width_p-1:0]   rs_data_o,
    input  logic [write_ports_p-1:0]               rd_w_v_i,
    input  logic [write_ports_p*addr_width_lp-1:0] rd_addr_i,
    input  logic [write_ports_p*data_width_p-1:0]  rd_data_i
);

    localparam int unsigned num_regs_lp = 1 << addr_width_lp;

    bp_be_wr_pkt_s [wr_ports_max_gp-1:0]        wr_pkts;
    logic [num_regs_lp-1:0][data_width_p-1:0]   mem_r;
    logic [num_regs_lp-1:0][data_width_p-1:0]   mem_n;
    bp_be_wr_sel_s                              entry_sel;

    // Pack the write ports into fixed-size packets; unused slots are never valid.
    for (genvar p = 0; p < wr_ports_max_gp; p++) begin : g_wr_pkt
        if (p < write_ports_p) begin : g_used
            assign wr_pkts[p].v    = rd_w_v_i[p];
            assign wr_pkts[p].addr = rd_addr_i[p*addr_width_lp +: addr_width_lp];
            assign wr_pkts[p].data = max_data_width_gp'(rd_data_i[p*data_width_p +: data_width_p]);
        end else begin : g_unused
            assign wr_pkts[p] = '0;
        end
    end

    // Post-write view of every entry; x0 stays zero because its writes never resolve.
    always_comb begin
        mem_n     = mem_r;
        entry_sel = '0;
        for (int unsigned e = 0; e < num_regs_lp; e++) begin
            entry_sel = bp_be_resolve_write(wr_pkts, addr_width_lp'(e), zero_x0_p);
            if (entry_sel.hit) begin
                mem_n[e] = data_width_p'(wr_pkts[entry_sel.idx].data);
            end
        end
    end

    // Storage array.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_r <= '0;
        end else begin
            mem_r <= mem_n;
        end
    end

    // One read slot per port, fed with write-first lookup data.
    for (genvar i = 0; i < read_ports_p; i++) begin : g_read
        logic [addr_width_lp-1:0] addr;
        logic [data_width_p-1:0]  fwd_data;

        assign addr     = rs_addr_i[i*addr_width_lp +: addr_width_lp];
        assign fwd_data = mem_n[addr];

        bp_be_regfile_read_slot #(
            .data_width_p (data_width_p),
            .zero_x0_p    (zero_x0_p)
        ) slot (
            .clk_i         (clk_i),
            .reset_i       (reset_i),
            .rs_r_v_i      (rs_r_v_i[i]),
            .rs_addr_i     (addr),
            .rd_fwd_data_i (fwd_data),
            .wr_pkts_i     (wr_pkts),
            .rs_data_o     (rs_data_o[i*data_width_p +: data_width_p])
        );
    end

endmodule

// File: tb/tb_bp_be_regfile_mp.sv
// Directed self-checking bench: integer file (x0 hardwired) and FP file (x0 ordinary).
module tb_bp_be_regfile_mp;
    import bp_be_pkg::*;

    localparam int unsigned A  = 5;
    localparam int unsigned D  = 64;
    localparam int unsigned DF = 65;
    localparam int unsigned R  = 3;
    localparam int unsigned W  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [R-1:0]    rs_v;
    logic [R*A-1:0]  rs_addr;
    logic [R*D-1:0]  rs_data;
    logic [W-1:0]    wv;
    logic [W*A-1:0]  waddr;
    logic [W*D-1:0]  wdata;

    logic [0:0]      fp_rs_v;
    logic [A-1:0]    fp_rs_addr;
    logic [DF-1:0]   fp_rs_data;
    logic [W-1:0]    fp_wv;
    logic [W*A-1:0]  fp_waddr;
    logic [W*DF-1:0] fp_wdata;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bp_be_regfile_mp #(
        .bp_params_p   (e_bp_default_cfg),
        .data_width_p  (D),
        .read_ports_p  (R),
        .write_ports_p (W),
        .zero_x0_p     (1'b1)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .rs_r_v_i  (rs_v),
        .rs_addr_i (rs_addr),
        .rs_data_o (rs_data),
        .rd_w_v_i  (wv),
        .rd_addr_i (waddr),
        .rd_data_i (wdata)
    );

    bp_be_regfile_mp #(
        .bp_params_p   (e_bp_default_cfg),
        .data_width_p  (DF),
        .read_ports_p  (1),
        .write_ports_p (W),
        .zero_x0_p     (1'b0)
    ) dut_fp (
        .clk_i     (clk),
        .reset_i   (reset),
        .rs_r_v_i  (fp_rs_v),
        .rs_addr_i (fp_rs_addr),
        .rs_data_o (fp_rs_data),
        .rd_w_v_i  (fp_wv),
        .rd_addr_i (fp_waddr),
        .rd_data_i (fp_wdata)
    );

    task automatic idle();
        rs_v = '0; rs_addr = '0; wv = '0; waddr = '0; wdata = '0;
        fp_rs_v = '0; fp_rs_addr = '0; fp_wv = '0; fp_waddr = '0; fp_wdata = '0;
    endtask

    task automatic rd(input int p, input logic [A-1:0] a);
        rs_v[p] = 1'b1;
        rs_addr[p*A +: A] = a;
    endtask

    task automatic wr(input int p, input logic [A-1:0] a, input logic [D-1:0] d);
        wv[p] = 1'b1;
        waddr[p*A +: A] = a;
        wdata[p*D +: D] = d;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [D-1:0] port(input int p);
        return rs_data[p*D +: D];
    endfunction

    task automatic check(input string tag, input logic [DF-1:0] obs, input logic [DF-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        #1;
        check("reset_out0", 65'(port(0)), 65'h0);
        check("reset_out2", 65'(port(2)), 65'h0);
        check("reset_fp",   fp_rs_data,   65'h0);
        tick(); tick();
        reset = 1'b0;

        // Read x5 after reset.
        rd(0, 5'd5);
        tick();
        check("rd_x5_after_reset", 65'(port(0)), 65'h0);

        // Two writes to x7 with a same-cycle read: youngest write forwarded.
        idle();
        wr(0, 5'd7, 64'h11);
        wr(1, 5'd7, 64'h22);
        rd(0, 5'd7);
        tick();
        check("wr_conflict_fwd", 65'(port(0)), 65'h22);
        idle();
        rd(1, 5'd7);
        tick();
        check("wr_conflict_later", 65'(port(1)), 65'h22);

        // Hold on port 2 with a later write to the held address.
        idle();
        wr(0, 5'd3, 64'hAA);
        tick();
        idle();
        rd(2, 5'd3);
        tick();
        check("hold_t1", 65'(port(2)), 65'hAA);
        idle();
        tick();
        check("hold_t2", 65'(port(2)), 65'hAA);
        tick();
        check("hold_t3", 65'(port(2)), 65'hAA);
        wr(1, 5'd3, 64'hBB);
        #3;
        check("hold_before_edge", 65'(port(2)), 65'hAA);
        tick();
        check("hold_replaced", 65'(port(2)), 65'hBB);

        // Two writes to a held address: youngest replaces the hold.
        idle();
        wr(0, 5'd3, 64'hC0);
        wr(1, 5'd3, 64'hC1);
        tick();
        check("hold_conflict", 65'(port(2)), 65'hC1);
        idle();
        tick();
        check("hold_stable", 65'(port(2)), 65'hC1);

        // x0 rule: hardwired on the integer file, ordinary on the FP file.
        idle();
        wr(0, 5'd0, 64'hFF);
        fp_wv[0] = 1'b1; fp_waddr[0 +: A] = 5'd0; fp_wdata[0 +: DF] = 65'hFF;
        tick();
        idle();
        rd(0, 5'd0);
        fp_rs_v = 1'b1; fp_rs_addr = 5'd0;
        tick();
        check("x0_int", 65'(port(0)), 65'h0);
        check("x0_fp",  fp_rs_data,   65'hFF);
        idle();
        wr(1, 5'd0, 64'hEE);
        tick();
        check("x0_int_hold", 65'(port(0)), 65'h0);

        // FP file full width incl. bit 64.
        idle();
        fp_wv[1] = 1'b1; fp_waddr[A +: A] = 5'd9; fp_wdata[DF +: DF] = {1'b1, 64'h1234};
        fp_rs_v = 1'b1; fp_rs_addr = 5'd9;
        tick();
        check("fp_wide_fwd", fp_rs_data, {1'b1, 64'h1234});

        // New request beats a write to the old held address.
        idle();
        wr(0, 5'd9, 64'h99);
        wr(1, 5'd4, 64'h44);
        tick();
        idle();
        rd(1, 5'd4);
        tick();
        check("hold_x4", 65'(port(1)), 65'h44);
        idle();
        rd(1, 5'd9);
        wr(0, 5'd4, 64'h55);
        tick();
        check("new_req_wins", 65'(port(1)), 65'h99);
        idle();
        wr(0, 5'd4, 64'h66);
        tick();
        check("old_addr_dropped", 65'(port(1)), 65'h99);
        idle();
        rd(0, 5'd4);
        tick();
        check("x4_later", 65'(port(0)), 65'h66);

        // Asynchronous reset between edges; writes during reset ignored.
        idle();
        #2;
        reset = 1'b1;
        #1;
        check("async_out0", 65'(port(0)), 65'h0);
        check("async_out1", 65'(port(1)), 65'h0);
        check("async_out2", 65'(port(2)), 65'h0);
        check("async_fp",   fp_rs_data,   65'h0);
        wr(0, 5'd7, 64'h77);
        tick();
        idle();
        reset = 1'b0;
        rd(0, 5'd7);
        rd(2, 5'd3);
        tick();
        check("post_reset_x7", 65'(port(0)), 65'h0);
        check("post_reset_x3", 65'(port(2)), 65'h0);
        idle();
        rd(1, 5'd4);
        tick();
        check("post_reset_x4", 65'(port(1)), 65'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
